// File: rtl/pulp_clock_div_multi.sv
// ============================================================================
// Module   : pulp_clock_div_multi
// Brief    : Multi-channel clock divider/gater with glitch-free reconfiguration
//            and enable/disable applied only at output period boundaries.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pulp_clock_gating (
    input  logic i_clk,
    input  logic i_en,
    input  logic i_test_en,
    output logic o_clk
);
    logic r_en_latch;

    always_latch begin
        if (!i_clk) r_en_latch <= i_en | i_test_en;
    end

    assign o_clk = i_clk & r_en_latch;
endmodule

module pulp_clock_mux2 (
    input  logic i_clk0,
    input  logic i_clk1,
    input  logic i_sel,
    output logic o_clk
);
    assign o_clk = i_sel ? i_clk1 : i_clk0;
endmodule

module pulp_clock_div_multi #(
    parameter int NUM_CH  = 4,
    parameter int DIV_W   = 8,
    parameter int RST_DIV = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    test_mode_i,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic [NUM_CH-1:0]       cfg_valid_i,
    input  logic [NUM_CH*DIV_W-1:0] cfg_div_i,
    output logic [NUM_CH-1:0]       cfg_ready_o,
    output logic [NUM_CH-1:0]       clk_o,
    output logic [NUM_CH-1:0]       busy_o
);
    localparam logic [1:0]       c_st_idle   = 2'd0;
    localparam logic [1:0]       c_st_run    = 2'd1;
    localparam logic [1:0]       c_st_drain  = 2'd2;
    localparam logic [1:0]       c_st_switch = 2'd3;
    localparam logic [DIV_W-1:0] c_rst_div   = DIV_W'(RST_DIV);
    localparam logic [DIV_W-1:0] c_one       = DIV_W'(1);

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_ch
            logic [1:0]       r_state, w_state_nxt;
            logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
            logic [DIV_W-1:0] r_div_q, w_div_nxt;
            logic [DIV_W-1:0] r_pend_q, w_pend_nxt;
            logic             r_pend_vld, w_pend_vld_nxt;
            logic             r_cfg_ready, w_cfg_ready_nxt;
            logic             r_div_out, w_div_out_nxt;
            logic             r_icg_en, w_icg_en_nxt;
            logic             r_sel_byp, w_sel_byp_nxt;
            logic [DIV_W-1:0] w_cfg, w_new_div;
            logic             w_hs, w_byp, w_bnd, w_pend_any, w_new_byp;
            logic             w_icg_clk;

            assign w_cfg      = cfg_div_i[k*DIV_W +: DIV_W];
            assign w_hs       = cfg_valid_i[k] & r_cfg_ready;
            assign w_byp      = (r_div_q <= c_one);
            // Bypass has a boundary every cycle; divided ends on the last count
            assign w_bnd      = w_byp | (r_cnt == r_div_q - c_one);
            assign w_pend_any = r_pend_vld | w_hs;
            assign w_new_div  = r_pend_vld ? r_pend_q : w_cfg;
            assign w_new_byp  = (w_new_div <= c_one);

            always_comb begin
                w_state_nxt     = r_state;
                w_cnt_nxt       = r_cnt;
                w_div_nxt       = r_div_q;
                w_pend_nxt      = r_pend_q;
                w_pend_vld_nxt  = r_pend_vld;
                w_cfg_ready_nxt = r_cfg_ready;
                w_div_out_nxt   = 1'b0;
                case (r_state)
                    c_st_idle: begin
                        if (w_hs) w_div_nxt = w_cfg;
                        if (en_i[k]) begin
                            w_state_nxt = c_st_run;
                            w_cnt_nxt   = '0;
                        end
                    end
                    c_st_run, c_st_drain: begin
                        if (!w_byp) w_div_out_nxt = (r_cnt < (r_div_q >> 1));
                        w_cnt_nxt = w_bnd ? '0 : r_cnt + c_one;
                        if (w_hs) w_pend_nxt = w_cfg;
                        if (w_bnd) begin
                            w_pend_vld_nxt = 1'b0;
                            if (w_pend_any) begin
                                w_div_nxt = w_new_div;
                                if (w_new_byp != w_byp) begin
                                    w_state_nxt     = c_st_switch;
                                    w_cfg_ready_nxt = 1'b0;
                                end else begin
                                    w_state_nxt     = en_i[k] ? c_st_run : c_st_idle;
                                    w_cfg_ready_nxt = 1'b1;
                                end
                            end else begin
                                w_state_nxt = en_i[k] ? c_st_run : c_st_idle;
                            end
                        end else begin
                            w_pend_vld_nxt  = w_pend_any;
                            w_cfg_ready_nxt = ~w_pend_any;
                            w_state_nxt     = (!en_i[k] || w_pend_any) ? c_st_drain : c_st_run;
                        end
                    end
                    c_st_switch: begin
                        w_cnt_nxt       = '0;
                        w_cfg_ready_nxt = 1'b1;
                        w_state_nxt     = en_i[k] ? c_st_run : c_st_idle;
                    end
                    default: begin
                        w_state_nxt = c_st_idle;
                    end
                endcase
            end

            // Mux select only moves outside SWITCH, when both clock inputs are low
            assign w_sel_byp_nxt = (w_state_nxt == c_st_switch) ? r_sel_byp
                                                                : (w_div_nxt <= c_one);
            assign w_icg_en_nxt  = ((w_state_nxt == c_st_run) || (w_state_nxt == c_st_drain))
                                   && (w_div_nxt <= c_one);

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_state     <= c_st_idle;
                    r_cnt       <= '0;
                    r_div_q     <= c_rst_div;
                    r_pend_q    <= '0;
                    r_pend_vld  <= 1'b0;
                    r_cfg_ready <= 1'b1;
                    r_div_out   <= 1'b0;
                    r_icg_en    <= 1'b0;
                    r_sel_byp   <= (c_rst_div <= c_one);
                end else begin
                    r_state     <= w_state_nxt;
                    r_cnt       <= w_cnt_nxt;
                    r_div_q     <= w_div_nxt;
                    r_pend_q    <= w_pend_nxt;
                    r_pend_vld  <= w_pend_vld_nxt;
                    r_cfg_ready <= w_cfg_ready_nxt;
                    r_div_out   <= w_div_out_nxt;
                    r_icg_en    <= w_icg_en_nxt;
                    r_sel_byp   <= w_sel_byp_nxt;
                end
            end

            pulp_clock_gating u_icg (
                .i_clk     (clk_i),
                .i_en      (r_icg_en),
                .i_test_en (test_mode_i),
                .o_clk     (w_icg_clk)
            );

            pulp_clock_mux2 u_mux (
                .i_clk0 (r_div_out),
                .i_clk1 (w_icg_clk),
                .i_sel  (r_sel_byp | test_mode_i),
                .o_clk  (clk_o[k])
            );

            assign cfg_ready_o[k] = r_cfg_ready;
            assign busy_o[k]      = (r_state == c_st_drain) || (r_state == c_st_switch);
        end
    endgenerate
endmodule

`default_nettype wire

// File: tb/tb_pulp_clock_div_multi.sv
// ============================================================================
// Module   : tb_pulp_clock_div_multi
// Brief    : Randomised bench for pulp_clock_div_multi against a period-queue
//            reference model of each channel's output waveform.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pulp_clock_div_multi;
    localparam int NUM_CH  = 4;
    localparam int DIV_W   = 8;
    localparam int RST_DIV = 1;
    localparam int N_CYC   = 6000;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic                    test_mode_i;
    logic [NUM_CH-1:0]       en_i;
    logic [NUM_CH-1:0]       cfg_valid_i;
    logic [NUM_CH*DIV_W-1:0] cfg_div_i;
    logic [NUM_CH-1:0]       cfg_ready_o;
    logic [NUM_CH-1:0]       clk_o;
    logic [NUM_CH-1:0]       busy_o;

    pulp_clock_div_multi #(
        .NUM_CH  (NUM_CH),
        .DIV_W   (DIV_W),
        .RST_DIV (RST_DIV)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .test_mode_i (test_mode_i),
        .en_i        (en_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_div_i   (cfg_div_i),
        .cfg_ready_o (cfg_ready_o),
        .clk_o       (clk_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Model: mode 0 = stopped, 1 = producing periods, 2 = one-cycle mux gap.
    // wave holds the remaining output levels of the current period;
    // level 2 means "follows clk_i" (bypass pulse).
    int m_mode   [NUM_CH];
    int m_div    [NUM_CH];
    bit m_pend_v [NUM_CH];
    int m_pend   [NUM_CH];
    bit m_ready  [NUM_CH];
    bit m_busy   [NUM_CH];
    int m_out    [NUM_CH];
    int wave     [NUM_CH][$];
    bit drop     [NUM_CH];
    int cfg_val  [NUM_CH];

    function automatic void push_period(int ch);
        if (m_div[ch] <= 1) wave[ch].push_back(2);
        else for (int i = 0; i < m_div[ch]; i++) wave[ch].push_back((i < m_div[ch] / 2) ? 1 : 0);
    endfunction

    function automatic void model_reset(int ch);
        // a bypass pulse already latched by the ICG still completes
        m_out[ch]    = (m_mode[ch] == 1 && m_div[ch] <= 1) ? 2 : 0;
        m_mode[ch]   = 0;
        m_div[ch]    = RST_DIV;
        m_pend_v[ch] = 1'b0;
        m_ready[ch]  = 1'b1;
        m_busy[ch]   = 1'b0;
        wave[ch].delete();
    endfunction

    function automatic void model_step(int ch);
        bit hs;
        bit sw;
        hs = cfg_valid_i[ch] & m_ready[ch];
        drop[ch] = hs;
        case (m_mode[ch])
            0: begin
                m_out[ch]  = 0;
                m_busy[ch] = 1'b0;
                if (hs) m_div[ch] = cfg_val[ch];
                if (en_i[ch]) begin
                    m_mode[ch] = 1;
                    wave[ch].delete();
                    push_period(ch);
                end
            end
            2: begin
                m_out[ch]   = 0;
                m_busy[ch]  = 1'b0;
                m_ready[ch] = 1'b1;
                if (en_i[ch]) begin
                    m_mode[ch] = 1;
                    push_period(ch);
                end else m_mode[ch] = 0;
            end
            default: begin
                m_out[ch] = wave[ch].pop_front();
                if (hs) begin
                    m_pend_v[ch] = 1'b1;
                    m_pend[ch]   = cfg_val[ch];
                end
                if (wave[ch].size() == 0) begin
                    m_busy[ch] = 1'b0;
                    sw = 1'b0;
                    if (m_pend_v[ch]) begin
                        sw = ((m_pend[ch] <= 1) != (m_div[ch] <= 1));
                        m_div[ch]    = m_pend[ch];
                        m_pend_v[ch] = 1'b0;
                        m_ready[ch]  = !sw;
                    end
                    if (sw) begin
                        m_mode[ch] = 2;
                        m_busy[ch] = 1'b1;
                    end else if (en_i[ch]) push_period(ch);
                    else m_mode[ch] = 0;
                end else begin
                    m_busy[ch]  = !en_i[ch] || m_pend_v[ch];
                    m_ready[ch] = !m_pend_v[ch];
                end
            end
        endcase
    endfunction

    function automatic int pick_div();
        int r;
        r = $urandom_range(0, 39);
        if (r < 4) return r & 1;
        if (r == 39) return (1 << DIV_W) - 1;
        return $urandom_range(2, 9);
    endfunction

    initial begin
        bit tm;
        bit skip;
        int tm_left;
        tm = 1'b0;
        tm_left = 0;
        rst_i = 1'b1;
        test_mode_i = 1'b0;
        en_i = '0;
        cfg_valid_i = '0;
        cfg_div_i = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_mode[ch] = 0;
            drop[ch] = 1'b0;
            cfg_val[ch] = 0;
            model_reset(ch);
        end
        repeat (3) @(posedge clk_i);

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(posedge clk_i);
            #1;
            rst_i = (cyc > 50) && ($urandom_range(0, 399) == 0);
            skip = 1'b0;
            if (tm) begin
                tm_left--;
                if (tm_left == 0) begin
                    tm = 1'b0;
                    skip = 1'b1;
                end
            end else if (cyc > 20 && $urandom_range(0, 499) == 0) begin
                tm = 1'b1;
                tm_left = $urandom_range(4, 25);
                skip = 1'b1;
            end
            test_mode_i = tm;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (drop[ch]) cfg_valid_i[ch] = 1'b0;
                if (en_i[ch]) begin
                    if ($urandom_range(0, 59) == 0) en_i[ch] = 1'b0;
                end else if ($urandom_range(0, 14) == 0) en_i[ch] = 1'b1;
                if (!cfg_valid_i[ch]) begin
                    if ($urandom_range(0, 39) == 0) begin
                        cfg_valid_i[ch] = 1'b1;
                        cfg_val[ch] = pick_div();
                        cfg_div_i[ch*DIV_W +: DIV_W] = DIV_W'(cfg_val[ch]);
                    end else begin
                        cfg_div_i[ch*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 255));
                    end
                end
            end

            #2;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (!skip)
                    chk($sformatf("c%0d ch%0d clk_hi", cyc, ch), int'(clk_o[ch]),
                        tm ? 1 : int'(m_out[ch] != 0));
                chk($sformatf("c%0d ch%0d ready", cyc, ch), int'(cfg_ready_o[ch]), int'(m_ready[ch]));
                chk($sformatf("c%0d ch%0d busy", cyc, ch), int'(busy_o[ch]), int'(m_busy[ch]));
            end

            #5;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (!skip)
                    chk($sformatf("c%0d ch%0d clk_lo", cyc, ch), int'(clk_o[ch]),
                        tm ? 0 : int'(m_out[ch] == 1));
                if (rst_i) begin
                    drop[ch] = 1'b0;
                    model_reset(ch);
                end else begin
                    model_step(ch);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
